// File: rtl/dec_to_bin.sv
// dec_to_bin: serial ASCII decimal field -> binary, one char per clk.
// Ports: clk, rst(sync hi), ascii_ready/ascii_in -> binary_out/binary_ready/err. Opt: DEC_TO_BIN_SIGN_EN.
module dec_to_bin #(
  parameter int NUM_CHARS = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ascii_ready,
  input  logic [8*NUM_CHARS-1:0] ascii_in,
  output logic [OUT_WIDTH-1:0]   binary_out,
  output logic                   binary_ready,
  output logic [1:0]             err
);
  localparam int XW = OUT_WIDTH + 4;
  localparam int IW = $clog2(NUM_CHARS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_CHARS - 1);
  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_ILL   = 2'd1;
  localparam logic [1:0] E_OVF   = 2'd2;
  localparam logic [1:0] E_EMPTY = 2'd3;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {LEAD, DIGITS, TRAIL, MINUS} phase_t;

  state_t state, state_n;
  phase_t phase, phase_n;
  logic [8*NUM_CHARS-1:0] sh, sh_n;
  logic [OUT_WIDTH-1:0] acc, acc_n, out_n;
  logic [IW-1:0] idx, idx_n;
  logic [1:0] serr, serr_n, err_n;
  logic neg, neg_n, rdy_n, prev, start, take;

  logic [7:0] c;
  logic is_dig, is_spc, ovf;
  logic [XW-1:0] mac, lim;
  logic [OUT_WIDTH-1:0] sat, fin_val;
  logic [1:0] fin_err;

  assign start  = ascii_ready & ~prev;
  assign c      = sh[8*NUM_CHARS-1 -: 8];
  assign is_dig = (c >= 8'h30) && (c <= 8'h39);
  assign is_spc = (c == 8'h20);
  assign mac    = XW'(acc) * XW'(10) + XW'(c[3:0]);

  // neg stays 0 unless the sign option lets '-' through
  assign lim = neg ? (XW'(1) << (OUT_WIDTH - 1))
                   : XW'({OUT_WIDTH{1'b1}});
  assign sat = neg ? (OUT_WIDTH'(1) << (OUT_WIDTH - 1))
                   : {OUT_WIDTH{1'b1}};
  assign ovf = mac > lim;

  always_comb begin
    fin_err = serr;
    if (serr == E_OK && (phase == LEAD || phase == MINUS))
      fin_err = E_EMPTY;
    fin_val = neg ? -acc : acc;
    if (fin_err == E_ILL || fin_err == E_EMPTY)
      fin_val = '0;
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    sh_n    = sh;
    acc_n   = acc;
    idx_n   = idx;
    serr_n  = serr;
    neg_n   = neg;
    out_n   = binary_out;
    err_n   = err;
    rdy_n   = binary_ready;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sh_n    = ascii_in;
          acc_n   = '0;
          idx_n   = '0;
          phase_n = LEAD;
          serr_n  = E_OK;
          neg_n   = 1'b0;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (!ascii_ready) begin
          state_n = IDLE;
        end else begin
          sh_n  = sh << 8;
          idx_n = idx + IW'(1);
          if (idx == LAST)
            state_n = DONE;
          // first error freezes the scan result
          if (serr == E_OK) begin
            unique case (phase)
              LEAD: begin
                unique case (1'b1)
                  is_spc: ;
                  is_dig: begin
                    phase_n = DIGITS;
                    take    = 1'b1;
                  end
                  default: begin
`ifdef DEC_TO_BIN_SIGN_EN
                    if (c == 8'h2d) begin
                      phase_n = MINUS;
                      neg_n   = 1'b1;
                    end else
`endif
                    serr_n = E_ILL;
                  end
                endcase
              end
              MINUS: begin
                unique case (1'b1)
                  is_dig: begin
                    phase_n = DIGITS;
                    take    = 1'b1;
                  end
                  is_spc:  serr_n = E_EMPTY;
                  default: serr_n = E_ILL;
                endcase
              end
              DIGITS: begin
                unique case (1'b1)
                  is_dig:  take    = 1'b1;
                  is_spc:  phase_n = TRAIL;
                  default: serr_n  = E_ILL;
                endcase
              end
              TRAIL: begin
                if (!is_spc)
                  serr_n = E_ILL;
              end
            endcase
            if (take) begin
              if (ovf) begin
                serr_n = E_OVF;
                acc_n  = sat;
              end else begin
                acc_n = mac[OUT_WIDTH-1:0];
              end
            end
          end
        end
      end
      DONE: begin
        if (!ascii_ready) begin
          rdy_n   = 1'b0;
          state_n = IDLE;
        end else begin
          rdy_n = 1'b1;
          out_n = fin_val;
          err_n = fin_err;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= LEAD;
      sh           <= '0;
      acc          <= '0;
      idx          <= '0;
      serr         <= E_OK;
      neg          <= 1'b0;
      prev         <= 1'b0;
      binary_out   <= '0;
      binary_ready <= 1'b0;
      err          <= E_OK;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      sh           <= sh_n;
      acc          <= acc_n;
      idx          <= idx_n;
      serr         <= serr_n;
      neg          <= neg_n;
      prev         <= ascii_ready;
      binary_out   <= out_n;
      binary_ready <= rdy_n;
      err          <= err_n;
    end
  end
endmodule

// File: tb/tb_dec_to_bin.sv
// tb_dec_to_bin: directed vectors, token-level model, per-cycle compare.
// Ports driven: clk, rst, ascii_ready, ascii_in; observes all outputs.
module tb_dec_to_bin;
  logic         clk = 1'b0;
  logic         rst;
  logic         ascii_ready;
  logic [127:0] ascii_in;
  logic [31:0]  binary_out;
  logic         binary_ready;
  logic [1:0]   err;

  int checks   = 0;
  int failures = 0;

  logic        chk_en = 1'b0;
  logic        exp_rdy;
  logic [31:0] exp_out;
  logic [1:0]  exp_err;
  logic [31:0] last_mo;
  logic [1:0]  last_me;

  always #5 clk = ~clk;

  dec_to_bin #(.NUM_CHARS(16), .OUT_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .ascii_ready(ascii_ready),
    .ascii_in(ascii_in),
    .binary_out(binary_out),
    .binary_ready(binary_ready),
    .err(err)
  );

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (binary_ready !== exp_rdy || binary_out !== exp_out ||
          err !== exp_err) begin
        failures++;
        $display("FAIL cycle t=%0t got rdy=%0b out=%h err=%0d want rdy=%0b out=%h err=%0d",
                 $time, binary_ready, binary_out, err,
                 exp_rdy, exp_out, exp_err);
      end
    end
  end

  function automatic string pad(input string s);
    string p = s;
    while (p.len() < 16) p = {" ", p};
    return p;
  endfunction

  function automatic logic [127:0] fld(input string p);
    logic [127:0] f = '0;
    for (int i = 0; i < 16; i++) f[8*(15-i) +: 8] = p[i];
    return f;
  endfunction

  // strip surrounding spaces, then parse the token as a decimal number
  function automatic void model(input string s,
                                output logic [31:0] o,
                                output logic [1:0] e);
    int first = -1;
    int last = -1;
    int st;
    bit neg = 0;
    longint v = 0;
    longint maxv;
    byte ch;
    for (int i = 0; i < 16; i++) begin
      if (s[i] != 8'h20) begin
        if (first < 0) first = i;
        last = i;
      end
    end
    if (first < 0) begin o = 0; e = 3; return; end
    st = first;
`ifdef DEC_TO_BIN_SIGN_EN
    if (s[first] == 8'h2d) begin
      neg = 1;
      st = first + 1;
      if (st > last || s[st] == 8'h20) begin o = 0; e = 3; return; end
    end
`endif
    maxv = neg ? 64'd2147483648 : 64'd4294967295;
    for (int i = st; i <= last; i++) begin
      ch = s[i];
      if (ch < 8'h30 || ch > 8'h39) begin o = 0; e = 1; return; end
      v = v * 10 + longint'(ch - 8'h30);
      if (v > maxv) begin
        o = neg ? 32'h8000_0000 : 32'hffff_ffff;
        e = 2;
        return;
      end
    end
    o = neg ? 32'(-v) : 32'(v);
    e = 0;
  endfunction

  task automatic run(input string s, input int drop_at);
    string p = pad(s);
    logic [31:0] mo;
    logic [1:0] me;
    model(p, mo, me);
    if (drop_at == 0) begin last_mo = mo; last_me = me; end
    @(posedge clk); #2;
    ascii_in = fld(p);
    ascii_ready = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #2;
      if (n == 1) ascii_in = {$urandom, $urandom, $urandom, $urandom};
      if (drop_at != 0 && n == drop_at) ascii_ready = 1'b0;
      if (drop_at == 0 && n == 18) begin
        exp_rdy = 1'b1;
        exp_out = mo;
        exp_err = me;
      end
    end
    ascii_ready = 1'b0;
    @(posedge clk); #2;
    exp_rdy = 1'b0;
  endtask

  task automatic pin(input string name, input logic [31:0] wo,
                     input logic [1:0] we);
    checks++;
    if (last_mo !== wo || last_me !== we) begin
      failures++;
      $display("FAIL model_%s got out=%h err=%0d want out=%h err=%0d",
               name, last_mo, last_me, wo, we);
    end
    checks++;
    if (binary_out !== wo || err !== we) begin
      failures++;
      $display("FAIL dut_%s got out=%h err=%0d want out=%h err=%0d",
               name, binary_out, err, wo, we);
    end
  endtask

  initial begin
    rst = 1'b1;
    ascii_ready = 1'b0;
    ascii_in = '0;
    @(posedge clk); #2;
    exp_rdy = 1'b0;
    exp_out = '0;
    exp_err = '0;
    chk_en = 1'b1;
    checks++;
    if (binary_out !== 0 || err !== 0 || binary_ready !== 0) begin
      failures++;
      $display("FAIL reset got out=%h err=%0d rdy=%0b want 0 0 0",
               binary_out, err, binary_ready);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run("42", 0);               pin("r42", 32'd42, 2'd0);
    run("4294967295", 0);       pin("max", 32'hffff_ffff, 2'd0);
    run("4294967296", 0);       pin("ovf", 32'hffff_ffff, 2'd2);
    run("12a4", 0);             pin("ill", 32'd0, 2'd1);
    run("  12 34", 0);          pin("gap", 32'd0, 2'd1);
    run("0000000000000007", 0); pin("lz", 32'd7, 2'd0);
    run("", 0);                 pin("empty", 32'd0, 2'd3);
    run("42              ", 0); pin("left", 32'd42, 2'd0);
    run("99999999999x", 0);     pin("ovf_first", 32'hffff_ffff, 2'd2);
    run("x 12", 0);             pin("lead_ill", 32'd0, 2'd1);
    run("1234567890", 0);       pin("big", 32'd1234567890, 2'd0);
`ifdef DEC_TO_BIN_SIGN_EN
    run("-5", 0);               pin("neg5", 32'hffff_fffb, 2'd0);
    run("-2147483648", 0);      pin("negmax", 32'h8000_0000, 2'd0);
    run("-", 0);                pin("minus", 32'd0, 2'd3);
    run("-2147483649", 0);      pin("negovf", 32'h8000_0000, 2'd2);
`else
    run("-5", 0);               pin("neg5", 32'd0, 2'd1);
`endif

    run("7", 0);                pin("pre_drop", 32'd7, 2'd0);
    run("123", 6);
    checks++;
    if (binary_out !== 32'd7 || err !== 0 || binary_ready !== 0) begin
      failures++;
      $display("FAIL drop got out=%h err=%0d rdy=%0b want 7 0 0",
               binary_out, err, binary_ready);
    end
    run("99", 0);               pin("rerun", 32'd99, 2'd0);

    @(posedge clk); #2;
    ascii_in = fld(pad("123"));
    ascii_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    ascii_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_rdy = 1'b0;
    exp_out = '0;
    exp_err = '0;
    checks++;
    if (binary_out !== 0 || err !== 0 || binary_ready !== 0) begin
      failures++;
      $display("FAIL mid_rst got out=%h err=%0d rdy=%0b want 0 0 0",
               binary_out, err, binary_ready);
    end
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
